// File: rtl/ahb_multi_mode_arbiter.sv
// Purpose: AHB bus arbiter with fixed, round-robin and weighted round-robin modes plus starvation promotion.
// Latency: one cycle from request to registered grant; back-to-back handover with no idle cycle on release.
// Backpressure: the owner keeps the bus until hlast and hready coincide, or until it drops its request.
module ahb_multi_mode_arbiter #(
    parameter int MASTER_NUM   = 4,
    parameter int ARB_MODE     = 1,
    parameter int WEIGHT_W     = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                           hclk,
    input  logic                           hreset_n,
    input  logic [MASTER_NUM-1:0]          hreq,
    input  logic [MASTER_NUM-1:0]          hlast,
    input  logic                           hready,
    input  logic [MASTER_NUM*WEIGHT_W-1:0] hweight,
    output logic [MASTER_NUM-1:0]          hgrant,
    output logic [$clog2(MASTER_NUM)-1:0]  hmaster,
    output logic                           hsel
);
    localparam int IDX_W = $clog2(MASTER_NUM);
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q, state_d;
    logic [MASTER_NUM-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [STV_W-1:0]      starve_q [MASTER_NUM];
    logic [STV_W-1:0]      starve_d [MASTER_NUM];
    // Credits are held as "transfers used" so that the reset value (zero used)
    // corresponds to a full credit of max(hweight,1) without an async load.
    logic [WEIGHT_W-1:0]   used_q [MASTER_NUM];
    logic [WEIGHT_W-1:0]   used_d [MASTER_NUM];

    logic [WEIGHT_W-1:0]   wmax [MASTER_NUM];
    logic                  owner_req, abort_rel, normal_rel, release_w;
    logic [MASTER_NUM-1:0] cand, starve_vec;
    logic                  starve_hit, fix_hit, rr_hit, credit_ok;
    logic [IDX_W-1:0]      starve_idx, fix_idx, rr_idx, rr_base, rr_pos;
    logic [WEIGHT_W:0]     used_inc;
    logic                  win_vld, regrant, take;
    logic [IDX_W-1:0]      win_idx;

    // Effective weight: a programmed zero behaves as one.
    always_comb begin
        for (int i = 0; i < MASTER_NUM; i++) begin
            wmax[i] = (hweight[i*WEIGHT_W +: WEIGHT_W] == '0) ? WEIGHT_W'(1)
                                                              : hweight[i*WEIGHT_W +: WEIGHT_W];
        end
    end

    // Release detection, candidate set and the three ranking schemes.
    always_comb begin
        owner_req  = hreq[owner_q];
        abort_rel  = (state_q == BUSY) && !owner_req;
        normal_rel = (state_q == BUSY) && owner_req && hlast[owner_q] && hready;
        release_w  = abort_rel || normal_rel;
        cand       = hreq & ~(abort_rel ? grant_q : '0);

        starve_hit = 1'b0;
        starve_idx = '0;
        fix_hit    = 1'b0;
        fix_idx    = '0;
        for (int i = MASTER_NUM - 1; i >= 0; i--) begin
            starve_vec[i] = (STARVE_LIMIT != 0) && cand[i] && (starve_q[i] == STV_W'(STARVE_LIMIT));
            if (starve_vec[i]) begin
                starve_hit = 1'b1;
                starve_idx = IDX_W'(i);
            end
            if (cand[i]) begin
                fix_hit = 1'b1;
                fix_idx = IDX_W'(i);
            end
        end

        // Circular search starting just after the last owner; the closest hit wins.
        rr_base = release_w ? owner_q : ptr_q;
        rr_hit  = 1'b0;
        rr_idx  = '0;
        rr_pos  = '0;
        for (int k = MASTER_NUM; k >= 1; k--) begin
            rr_pos = IDX_W'((int'(rr_base) + k) % MASTER_NUM);
            if (cand[rr_pos]) begin
                rr_hit = 1'b1;
                rr_idx = rr_pos;
            end
        end

        used_inc  = {1'b0, used_q[owner_q]} + {{WEIGHT_W{1'b0}}, 1'b1};
        credit_ok = normal_rel && (used_inc < {1'b0, wmax[owner_q]});
    end

    // Winner selection: starvation first, then weighted hold, then the mode's own rule.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        regrant = 1'b0;
        if (starve_hit) begin
            win_vld = 1'b1;
            win_idx = starve_idx;
        end else if ((ARB_MODE == 2) && credit_ok) begin
            win_vld = 1'b1;
            win_idx = owner_q;
            regrant = 1'b1;
        end else if (ARB_MODE == 0) begin
            win_vld = fix_hit;
            win_idx = fix_idx;
        end else begin
            win_vld = rr_hit;
            win_idx = rr_idx;
        end
        take = win_vld && ((state_q == IDLE) || release_w);
    end

    // Ownership FSM next state: grant on arbitration, hold while busy, hand over on release.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (state_q == IDLE) begin
            if (take) begin
                state_d          = BUSY;
                grant_d          = '0;
                grant_d[win_idx] = 1'b1;
                owner_d          = win_idx;
            end
        end else if (release_w) begin
            ptr_d = owner_q;
            if (take) begin
                grant_d          = '0;
                grant_d[win_idx] = 1'b1;
                owner_d          = win_idx;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                owner_d = '0;
            end
        end
    end

    // Starvation and credit bookkeeping for the next cycle.
    always_comb begin
        for (int i = 0; i < MASTER_NUM; i++) begin
            used_d[i] = used_q[i];
            if (!hreq[i] || grant_q[i] || grant_d[i]) begin
                starve_d[i] = '0;
            end else if (starve_q[i] != STV_W'(STARVE_LIMIT)) begin
                starve_d[i] = starve_q[i] + STV_W'(1);
            end else begin
                starve_d[i] = starve_q[i];
            end
        end
        // An exhausted credit wraps back to full.
        if (normal_rel && !credit_ok) begin
            used_d[owner_q] = '0;
        end
        if (take) begin
            if (regrant) begin
                used_d[owner_q] = used_inc[WEIGHT_W-1:0];
            end else begin
                used_d[win_idx] = '0;
            end
        end
    end

    // State registers; reset clears the grant asynchronously.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= IDX_W'(MASTER_NUM - 1);
            for (int i = 0; i < MASTER_NUM; i++) begin
                starve_q[i] <= '0;
                used_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            for (int i = 0; i < MASTER_NUM; i++) begin
                starve_q[i] <= starve_d[i];
                used_q[i]   <= used_d[i];
            end
        end
    end

    assign hgrant  = grant_q;
    assign hmaster = owner_q;
    assign hsel    = |grant_q;

endmodule

// File: tb/tb_ahb_multi_mode_arbiter.sv
// Bench for ahb_multi_mode_arbiter: three instances (fixed, round-robin, weighted)
// share one stimulus stream; a behavioural model predicts each owner per edge and
// a negedge monitor compares grant, master index and select.
module tb_ahb_multi_mode_arbiter;
    localparam int N  = 4;
    localparam int WW = 4;

    bit              hclk;
    logic            hreset_n;
    logic [N-1:0]    hreq;
    logic [N-1:0]    hlast;
    logic            hready;
    logic [N*WW-1:0] hweight;
    logic [N-1:0]    gnt [3];
    logic [1:0]      mst [3];
    logic            sel [3];

    ahb_multi_mode_arbiter #(.MASTER_NUM(N), .ARB_MODE(0), .WEIGHT_W(WW), .STARVE_LIMIT(4)) u_fix (
        .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlast(hlast), .hready(hready),
        .hweight(hweight), .hgrant(gnt[0]), .hmaster(mst[0]), .hsel(sel[0]));
    ahb_multi_mode_arbiter #(.MASTER_NUM(N), .ARB_MODE(1), .WEIGHT_W(WW), .STARVE_LIMIT(16)) u_rr (
        .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlast(hlast), .hready(hready),
        .hweight(hweight), .hgrant(gnt[1]), .hmaster(mst[1]), .hsel(sel[1]));
    ahb_multi_mode_arbiter #(.MASTER_NUM(N), .ARB_MODE(2), .WEIGHT_W(WW), .STARVE_LIMIT(16)) u_wrr (
        .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlast(hlast), .hready(hready),
        .hweight(hweight), .hgrant(gnt[2]), .hmaster(mst[2]), .hsel(sel[2]));

    always #5 hclk = ~hclk;

    int n_checks;
    int n_fail;
    int exp_q[$];
    bit mdl_on;
    int mon_eo;

    // Reference model: owner (-1 = none), last-owner pointer, owner credit, wait counters.
    int m_owner [3];
    int m_ptr   [3];
    int m_cred  [3];
    int m_wait  [3][N];

    function automatic int limit_of(input int m);
        return (m == 0) ? 4 : 16;
    endfunction

    function automatic int wt(input int i);
        int w;
        w = int'(hweight[i*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic void mdl_reset();
        for (int m = 0; m < 3; m++) begin
            m_owner[m] = -1;
            m_ptr[m]   = N - 1;
            m_cred[m]  = 0;
            for (int i = 0; i < N; i++) m_wait[m][i] = 0;
        end
    endfunction

    function automatic void mdl_step(input int m);
        int  o, win, base, lim, new_o;
        bit  rel, normal, regrant, arb;
        o = m_owner[m];
        lim = limit_of(m);
        rel = 0; normal = 0; regrant = 0; win = -1;
        if (o >= 0) begin
            if (!hreq[o]) rel = 1;
            else if (hlast[o] && hready) begin
                rel = 1;
                normal = 1;
            end
        end
        arb = (o < 0) ? (hreq != '0) : rel;
        new_o = o;
        if (arb) begin
            for (int i = 0; i < N; i++)
                if (win < 0 && hreq[i] && lim != 0 && m_wait[m][i] == lim) win = i;
            if (win < 0 && m == 2 && normal && (m_cred[m] - 1) > 0) begin
                win = o;
                regrant = 1;
            end
            if (win < 0 && m == 0) begin
                for (int i = 0; i < N; i++) if (win < 0 && hreq[i]) win = i;
            end
            if (win < 0 && m != 0) begin
                base = rel ? o : m_ptr[m];
                for (int k = 1; k <= N; k++) if (win < 0 && hreq[(base + k) % N]) win = (base + k) % N;
            end
            if (rel) m_ptr[m] = o;
            new_o = win;
            if (regrant) m_cred[m] = m_cred[m] - 1;
            else if (win >= 0) m_cred[m] = wt(win);
        end
        for (int i = 0; i < N; i++) begin
            if (!hreq[i] || i == o || i == new_o) m_wait[m][i] = 0;
            else if (m_wait[m][i] < lim) m_wait[m][i] = m_wait[m][i] + 1;
        end
        m_owner[m] = new_o;
    endfunction

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0d, expected %0d at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Model follows the reset asynchronously as well.
    always @(negedge hreset_n) mdl_reset();

    // Scoreboard producer: one expected owner per instance per rising edge.
    always @(posedge hclk) begin
        if (!hreset_n) mdl_reset();
        else for (int m = 0; m < 3; m++) mdl_step(m);
        for (int m = 0; m < 3; m++) exp_q.push_back(m_owner[m]);
        mdl_on = 1;
    end

    // Scoreboard consumer: compare on the falling edge, away from the sampling edge.
    always @(negedge hclk) begin
        if (mdl_on) begin
            for (int m = 0; m < 3; m++) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty inst%0d at %0t", m, $time);
                end else begin
                    mon_eo = exp_q.pop_front();
                    if (!hreset_n) mon_eo = -1;
                    chk("hgrant", m, int'(gnt[m]), (mon_eo < 0) ? 0 : (1 << mon_eo));
                    chk("hmaster", m, int'(mst[m]), (mon_eo < 0) ? 0 : mon_eo);
                    chk("hsel", m, int'(sel[m]), (mon_eo < 0) ? 0 : 1);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset(input logic [N*WW-1:0] w);
        hreset_n = 1'b0;
        hreq     = '0;
        hlast    = '0;
        hready   = 1'b1;
        hweight  = w;
        cyc();
        cyc();
        hreset_n = 1'b1;
    endtask

    // Directed check of one instance's owner right after an edge.
    task automatic expect_own(input string nm, input int inst, input int eo);
        chk(nm, inst, int'(gnt[inst]), (eo < 0) ? 0 : (1 << eo));
    endtask

    int seq_rr  [5] = '{0, 1, 2, 3, 0};
    int seq_wrr [7] = '{0, 0, 0, 1, 2, 3, 0};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        hreset_n = 1'b0;
        hreq     = '0;
        hlast    = '0;
        hready   = 1'b1;
        hweight  = '0;

        // Fixed priority: lowest requester wins, holds through hready low, hands over without a gap.
        do_reset(16'h1111);
        expect_own("reset_grant", 0, -1);
        hreq = 4'b1010;
        cyc(); expect_own("fix_first", 0, 1);
        hlast = 4'b0010; hready = 1'b0;
        cyc(); expect_own("fix_hold_a", 0, 1);
        cyc(); expect_own("fix_hold_b", 0, 1);
        hready = 1'b1; hreq = 4'b1000;
        cyc(); expect_own("fix_handover", 0, 3);

        // Round-robin rotation with single-transfer transactions.
        do_reset(16'h1111);
        hreq = 4'b1111; hlast = 4'b1111; hready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(); expect_own("rr_rotation", 1, seq_rr[i]);
        end

        // Weighted round-robin, master0 weight 3.
        do_reset(16'h1113);
        hreq = 4'b1111; hlast = 4'b1111; hready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(); expect_own("wrr_sequence", 2, seq_wrr[i]);
        end

        // Starvation promotion in fixed priority with limit 4.
        do_reset(16'h1111);
        hreq = 4'b1001; hlast = 4'b1111; hready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(); expect_own("starve_wait", 0, 0);
        end
        cyc(); expect_own("starve_promote", 0, 3);

        // Abort: owner drops request, then nobody requests.
        do_reset(16'h1111);
        hreq = 4'b0011;
        cyc(); expect_own("abort_first", 1, 0);
        hreq = 4'b0010;
        cyc(); expect_own("abort_regrant", 1, 1);
        hreq = 4'b0000;
        cyc(); expect_own("abort_idle", 1, -1);

        // Asynchronous reset mid-transaction.
        hreq = 4'b0001;
        cyc();
        for (int m = 0; m < 3; m++) expect_own("pre_reset_own", m, 0);
        #2 hreset_n = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) expect_own("async_reset", m, -1);
        cyc();
        cyc();
        hreset_n = 1'b1;

        // Randomised traffic with varying weights and occasional reset pulses.
        for (int r = 0; r < 6; r++) begin
            logic [N*WW-1:0] w;
            for (int i = 0; i < N; i++) w[i*WW +: WW] = WW'($urandom_range(0, 4));
            do_reset(w);
            for (int c = 0; c < 500; c++) begin
                for (int i = 0; i < N; i++) begin
                    hreq[i]  = ($urandom_range(0, 3) != 0);
                    hlast[i] = ($urandom_range(0, 1) != 0);
                end
                hready   = ($urandom_range(0, 3) != 0);
                hreset_n = ($urandom_range(0, 299) != 0);
                cyc();
            end
            hreset_n = 1'b1;
        end

        hreq = '0;
        cyc();
        cyc();
        @(negedge hclk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
